intdiv_seq: RTL and testbench

INTDIV_SEQ -- requirements
Module: intdiv_seq

---
 rtl/intdiv_seq.sv | 136 +++++++++++++
 tb/tb_intdiv_seq.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/intdiv_seq.sv
`default_nettype none
// ============================================================================
// Module      : intdiv_seq
// Description : Sequential unsigned restoring divider, BPC quotient bits per
//               cycle, valid/ready handshake on both sides.
// Revision    : 1.0
// ============================================================================
module intdiv_seq #(
    parameter int W_N = 120,
    parameter int W_D = 60,
    parameter int BPC = 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W_N-1:0] N,
    input  logic [W_D-1:0] D,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [W_N-1:0] Q,
    output logic [W_D-1:0] R,
    output logic           dbz
);

    localparam int            CW     = $clog2(W_N / BPC + 1);
    localparam logic [CW-1:0] c_ITER = CW'(W_N / BPC);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;
    logic           w_accept;

    // Dividend shifts out of the top while quotient bits shift in at the bottom.
    logic [W_N-1:0] r_nq;
    logic [W_N-1:0] w_nq;
    logic [W_D:0]   r_rem;
    logic [W_D:0]   w_rem;
    logic [W_D-1:0] r_d;
    logic [CW-1:0]  r_cnt;
    logic           r_dbz;

    // One guard bit above the trial value makes the MSB of the difference the borrow.
    logic [W_D+1:0] w_trial;
    logic [W_D+1:0] w_diff;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        w_accept    = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = (D == '0) ? S_DONE : S_BUSY;
                end
            end
            S_BUSY: begin
                if (r_cnt == CW'(1)) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_comb begin
        w_rem   = r_rem;
        w_nq    = r_nq;
        w_trial = '0;
        w_diff  = '0;
        for (int i = 0; i < BPC; i++) begin
            w_trial = {w_rem, w_nq[W_N-1]};
            w_diff  = w_trial - {2'b00, r_d};
            w_rem   = w_diff[W_D+1] ? w_trial[W_D:0] : w_diff[W_D:0];
            w_nq    = {w_nq[W_N-2:0], ~w_diff[W_D+1]};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_nq  <= '0;
            r_rem <= '0;
            r_d   <= '0;
            r_cnt <= '0;
            r_dbz <= 1'b0;
        end else begin
            if (w_accept) begin
                r_d   <= D;
                r_cnt <= c_ITER;
                if (D == '0) begin
                    r_nq  <= '1;
                    r_rem <= {1'b0, N[W_D-1:0]};
                    r_dbz <= 1'b1;
                end else begin
                    r_nq  <= N;
                    r_rem <= '0;
                    r_dbz <= 1'b0;
                end
            end else if (r_state == S_BUSY) begin
                r_nq  <= w_nq;
                r_rem <= w_rem;
                r_cnt <= r_cnt - CW'(1);
            end
        end
    end

    assign Q   = r_nq;
    assign R   = r_rem[W_D-1:0];
    assign dbz = r_dbz;

endmodule
`default_nettype wire

// File: tb/tb_intdiv_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_intdiv_seq
// Description : Directed and randomised checks of intdiv_seq at BPC=1 and BPC=2.
// Revision    : 1.0
// ============================================================================
module tb_intdiv_seq;

    localparam int W_N = 120;
    localparam int W_D = 60;
    localparam int NR  = 500;

    logic           clk = 1'b0;
    logic           rst;
    logic           in_valid;
    logic           out_ready;
    logic           sel;
    logic [W_N-1:0] N;
    logic [W_D-1:0] D;

    logic           rdy1, vld1, dbz1, rdy2, vld2, dbz2;
    logic [W_N-1:0] q1, q2;
    logic [W_D-1:0] r1, r2;

    logic           in_ready, out_valid, dbz;
    logic [W_N-1:0] Q;
    logic [W_D-1:0] R;

    int n_chk  = 0;
    int n_fail = 0;

    logic [W_N-1:0] qn[$];
    logic [W_D-1:0] qd[$];

    always #5 clk = ~clk;

    intdiv_seq #(.W_N(W_N), .W_D(W_D), .BPC(1)) u_dut1 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid & ~sel), .in_ready(rdy1),
        .N(N), .D(D),
        .out_valid(vld1), .out_ready(out_ready & ~sel),
        .Q(q1), .R(r1), .dbz(dbz1)
    );

    intdiv_seq #(.W_N(W_N), .W_D(W_D), .BPC(2)) u_dut2 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid & sel), .in_ready(rdy2),
        .N(N), .D(D),
        .out_valid(vld2), .out_ready(out_ready & sel),
        .Q(q2), .R(r2), .dbz(dbz2)
    );

    assign in_ready  = sel ? rdy2 : rdy1;
    assign out_valid = sel ? vld2 : vld1;
    assign Q         = sel ? q2 : q1;
    assign R         = sel ? r2 : r1;
    assign dbz       = sel ? dbz2 : dbz1;

    task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Offers one pair, scrambles the inputs after accept, waits for the result.
    task automatic do_txn(input logic [W_N-1:0] n, input logic [W_D-1:0] d, output int lat);
        int w;
        @(negedge clk);
        w = 0;
        while (!in_ready && w < 10) begin
            @(negedge clk);
            w++;
        end
        N        = n;
        D        = d;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        N        = ~n;
        D        = ~d;
        chk("accept", in_ready, 0);
        lat = 0;
        while (!out_valid && lat < 300) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("done", out_valid, 1);
    endtask

    task automatic release_res;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("back_idle", in_ready, 1);
        chk("ov_low", out_valid, 0);
    endtask

    initial begin
        int             lat;
        logic           acc;
        logic           ok;
        int             ngen, nrcv, cyc;
        logic [127:0]   t;
        logic [W_N-1:0] en;
        logic [W_D-1:0] ed;
        logic [W_N-1:0] e_q;
        logic [W_N+W_D-1:0] prod;

        rst       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        sel       = 1'b0;
        N         = '0;
        D         = '0;
        #1;
        chk("rst_rdy", in_ready, 1);
        chk("rst_vld", out_valid, 0);
        chk("rst_q", Q, 0);
        chk("rst_r", R, 0);
        chk("rst_dbz", dbz, 0);
        @(posedge clk);
        #3 rst = 1'b1;

        do_txn(120'd100, 60'd7, lat);
        chk("q_100_7", Q, 14);
        chk("r_100_7", R, 2);
        chk("dbz_100_7", dbz, 0);
        chk("lat_100_7", lat, 120);
        release_res();

        e_q     = '0;
        e_q[60] = 1'b1;
        e_q[0]  = 1'b1;
        do_txn('1, '1, lat);
        chk("q_max_b1", Q, e_q);
        chk("r_max_b1", R, 0);
        chk("lat_max_b1", lat, 120);
        release_res();

        sel = 1'b1;
        do_txn('1, '1, lat);
        chk("q_max_b2", Q, e_q);
        chk("r_max_b2", R, 0);
        chk("lat_max_b2", lat, 60);
        release_res();
        sel = 1'b0;

        do_txn(120'h1234, '0, lat);
        chk("dbz_q", Q, {8'h00, {W_N{1'b1}}});
        chk("dbz_r", R, 60'h1234);
        chk("dbz_flag", dbz, 1);
        chk("dbz_lat", lat, 0);
        release_res();

        do_txn(120'd5, '1, lat);
        chk("small_q", Q, 0);
        chk("small_r", R, 5);
        chk("small_lat", lat, 120);
        repeat (10) begin
            @(posedge clk);
            #1;
            chk("hold_q", Q, 0);
            chk("hold_r", R, 5);
            chk("hold_rdy", in_ready, 0);
            chk("hold_vld", out_valid, 1);
        end
        release_res();

        // Reset lands between edges, 50 cycles into the iteration.
        @(negedge clk);
        N        = 120'd100;
        D        = 60'd7;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (50) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk("arst_rdy", in_ready, 1);
        chk("arst_vld", out_valid, 0);
        chk("arst_q", Q, 0);
        repeat (3) @(posedge clk);
        #3 rst = 1'b1;
        do_txn(120'd9, 60'd3, lat);
        chk("q_9_3", Q, 3);
        chk("r_9_3", R, 0);
        chk("lat_9_3", lat, 120);
        release_res();

        sel  = 1'b1;
        acc  = 1'b0;
        ngen = 0;
        nrcv = 0;
        cyc  = 0;
        while (nrcv < NR && cyc < 60000) begin
            @(negedge clk);
            cyc++;
            if (acc) begin
                in_valid = 1'b0;
                acc      = 1'b0;
            end
            if (!in_valid && ngen < NR) begin
                t = {$urandom(), $urandom(), $urandom(), $urandom()};
                N = t[W_N-1:0] >> $urandom_range(0, W_N - 1);
                t = {$urandom(), $urandom(), $urandom(), $urandom()};
                D = t[W_D-1:0] >> $urandom_range(0, W_D - 1);
                if ($urandom_range(0, 15) == 0) D = '0;
                in_valid = 1'b1;
            end
            out_ready = ($urandom_range(0, 3) != 0);
            if (in_valid && in_ready) begin
                qn.push_back(N);
                qd.push_back(D);
                ngen++;
                acc = 1'b1;
            end
            if (out_valid && out_ready) begin
                if (qn.size() == 0) begin
                    chk("rnd_order", 0, 1);
                end else begin
                    en = qn.pop_front();
                    ed = qd.pop_front();
                    if (ed == '0) begin
                        ok = (Q == '1) && (R == en[W_D-1:0]) && dbz;
                    end else begin
                        prod = {{W_D{1'b0}}, Q} * {{W_N{1'b0}}, ed} + {{W_N{1'b0}}, R};
                        ok   = (prod == {{W_D{1'b0}}, en}) && (R < ed) && !dbz;
                    end
                    chk("rnd_res", ok, 1);
                end
                nrcv++;
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk("rnd_count", nrcv, NR);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
